// File: rtl/mms_pkg.sv
// Shared memory-subsystem types: cache address/line layout and the D-cache controller state.
`ifndef CACHE_TAG_WD
`define CACHE_TAG_WD 8
`endif
`ifndef CACHE_INDEX_WD
`define CACHE_INDEX_WD 4
`endif
`ifndef CACHE_OFFSET
`define CACHE_OFFSET 2
`endif
`ifndef DATA_WD
`define DATA_WD 16
`endif

package mms_pkg;
    localparam int unsigned C_TAG_WD = `CACHE_TAG_WD;
    localparam int unsigned C_IDX_WD = `CACHE_INDEX_WD;
    localparam int unsigned C_OFF_WD = `CACHE_OFFSET;
    localparam int unsigned C_DW     = `DATA_WD;

    typedef struct packed {
        logic [C_TAG_WD-1:0] tag;
        logic [C_IDX_WD-1:0] idx;
        logic [C_OFF_WD-1:0] off;
    } cache_a_t;

    typedef struct packed {
        logic                valid;
        logic                dirty;
        logic [C_TAG_WD-1:0] cc_tag;
        logic [C_DW-1:0]     cc_data;
    } cache_line_t;

    typedef enum logic [3:0] {
        IDLE, LOOKUP, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, FL_SCAN, FL_REQ, FL_WAIT
    } ctrl_state_t;
endpackage

// File: rtl/dcache_array.sv
// Direct-mapped line storage: one combinational read port, one synchronous write port.
// Only the valid/dirty flags are reset; tag and data are don't-care while invalid.
module dcache_array
    import mms_pkg::*;
#(
    parameter int unsigned IDX_WD = C_IDX_WD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_WD-1:0] i_rd_idx,
    output cache_line_t       o_rd_line,
    input  logic              i_wr_en,
    input  logic [IDX_WD-1:0] i_wr_idx,
    input  cache_line_t       i_wr_line
);
    localparam int unsigned NUM_SETS = 2**IDX_WD;

    logic [NUM_SETS-1:0] r_valid;
    logic [NUM_SETS-1:0] r_dirty;
    logic [C_TAG_WD-1:0] r_tag  [NUM_SETS];
    logic [C_DW-1:0]     r_data [NUM_SETS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= i_wr_line.valid;
            r_dirty[i_wr_idx] <= i_wr_line.dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_line.cc_tag;
            r_data[i_wr_idx] <= i_wr_line.cc_data;
        end
    end

    assign o_rd_line.valid   = r_valid[i_rd_idx];
    assign o_rd_line.dirty   = r_dirty[i_rd_idx];
    assign o_rd_line.cc_tag  = r_tag[i_rd_idx];
    assign o_rd_line.cc_data = r_data[i_rd_idx];
endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate direct-mapped D-cache controller with full-cache flush.
//   state   | meaning
//   IDLE    | accept CPU request or start flush (flush has priority)
//   LOOKUP  | tag compare on registered request; respond on hit
//   WB_REQ  | victim writeback request held until mem_req_ready
//   WB_WAIT | wait for writeback ack
//   RF_REQ  | refill read request held until mem_req_ready
//   RF_WAIT | wait for refill data, install, replay LOOKUP
//   FL_SCAN | inspect line[cnt] for dirty data
//   FL_REQ  | flush writeback request for line[cnt]
//   FL_WAIT | wait for flush writeback ack, clear dirty
`ifndef CACHE_TAG_WD
`define CACHE_TAG_WD 8
`endif
`ifndef CACHE_INDEX_WD
`define CACHE_INDEX_WD 4
`endif
`ifndef CACHE_OFFSET
`define CACHE_OFFSET 2
`endif
`ifndef DATA_WD
`define DATA_WD 16
`endif

module dcache_ctrl
    import mms_pkg::*;
#(
    parameter int unsigned TAG_WD = `CACHE_TAG_WD,
    parameter int unsigned IDX_WD = `CACHE_INDEX_WD,
    parameter int unsigned OFF_WD = `CACHE_OFFSET,
    parameter int unsigned DW     = `DATA_WD
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_we,
    input  cache_a_t                        req_addr,
    input  logic [DW-1:0]                   req_wdata,
    output logic                            resp_valid,
    output logic [DW-1:0]                   resp_rdata,
    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic                            mem_req_we,
    output logic [TAG_WD+IDX_WD+OFF_WD-1:0] mem_req_addr,
    output logic [DW-1:0]                   mem_req_wdata,
    input  logic                            mem_resp_valid,
    input  logic [DW-1:0]                   mem_resp_rdata,
    input  logic                            flush_req,
    output logic                            flush_done
);
    localparam int unsigned NUM_SETS = 2**IDX_WD;

    ctrl_state_t                     r_state;
    logic                            r_idle;
    logic                            r_req_we;
    logic [TAG_WD-1:0]               r_req_tag;
    logic [IDX_WD-1:0]               r_req_idx;
    logic [DW-1:0]                   r_req_wdata;
    logic [IDX_WD:0]                 r_cnt;
    logic                            r_resp_valid;
    logic [DW-1:0]                   r_resp_rdata;
    logic                            r_mem_valid;
    logic                            r_mem_we;
    logic [TAG_WD+IDX_WD+OFF_WD-1:0] r_mem_addr;
    logic [DW-1:0]                   r_mem_wdata;
    logic                            r_flush_done;

    logic              w_flush_st;
    logic [IDX_WD-1:0] w_rd_idx;
    cache_line_t       w_line;
    logic              w_hit;
    logic              w_last;
    logic              w_wr_en;
    cache_line_t       w_wr_line;
    logic              w_unused_off;

    assign w_unused_off = ^req_addr.off;

    assign w_flush_st = (r_state == FL_SCAN) || (r_state == FL_REQ) || (r_state == FL_WAIT);
    assign w_rd_idx   = w_flush_st ? r_cnt[IDX_WD-1:0] : r_req_idx;
    assign w_hit      = w_line.valid && (w_line.cc_tag == r_req_tag);
    // Counter is one bit wider than the index so the terminal compare never aliases a wrap.
    assign w_last     = (r_cnt == (IDX_WD+1)'(NUM_SETS-1));

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_line = w_line;
        case (r_state)
            LOOKUP: if (w_hit && r_req_we) begin
                w_wr_en           = 1'b1;
                w_wr_line.dirty   = 1'b1;
                w_wr_line.cc_data = r_req_wdata;
            end
            RF_WAIT: if (mem_resp_valid) begin
                w_wr_en           = 1'b1;
                w_wr_line.valid   = 1'b1;
                w_wr_line.dirty   = 1'b0;
                w_wr_line.cc_tag  = r_req_tag;
                w_wr_line.cc_data = mem_resp_rdata;
            end
            FL_WAIT: if (mem_resp_valid) begin
                w_wr_en         = 1'b1;
                w_wr_line.dirty = 1'b0;
            end
            default: ;
        endcase
    end

    dcache_array #(.IDX_WD(IDX_WD)) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rd_idx  (w_rd_idx),
        .o_rd_line (w_line),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_rd_idx),
        .i_wr_line (w_wr_line)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idle       <= 1'b0;
            r_req_we     <= 1'b0;
            r_req_tag    <= '0;
            r_req_idx    <= '0;
            r_req_wdata  <= '0;
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_flush_done <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_flush_done <= 1'b0;
            r_idle       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (flush_req) begin
                        r_cnt   <= '0;
                        r_state <= FL_SCAN;
                    end else if (req_valid && r_idle) begin
                        r_req_we    <= req_we;
                        r_req_tag   <= req_addr.tag;
                        r_req_idx   <= req_addr.idx;
                        r_req_wdata <= req_wdata;
                        r_state     <= LOOKUP;
                    end else begin
                        r_idle <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (w_hit) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_req_we ? r_req_wdata : w_line.cc_data;
                        r_idle       <= 1'b1;
                        r_state      <= IDLE;
                    end else if (w_line.valid && w_line.dirty) begin
                        r_mem_valid <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= {w_line.cc_tag, r_req_idx, {OFF_WD{1'b0}}};
                        r_mem_wdata <= w_line.cc_data;
                        r_state     <= WB_REQ;
                    end else begin
                        r_mem_valid <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= {r_req_tag, r_req_idx, {OFF_WD{1'b0}}};
                        r_mem_wdata <= '0;
                        r_state     <= RF_REQ;
                    end
                end
                WB_REQ: if (mem_req_ready) begin
                    r_mem_valid <= 1'b0;
                    r_state     <= WB_WAIT;
                end
                WB_WAIT: if (mem_resp_valid) begin
                    r_mem_valid <= 1'b1;
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= {r_req_tag, r_req_idx, {OFF_WD{1'b0}}};
                    r_mem_wdata <= '0;
                    r_state     <= RF_REQ;
                end
                RF_REQ: if (mem_req_ready) begin
                    r_mem_valid <= 1'b0;
                    r_state     <= RF_WAIT;
                end
                RF_WAIT: if (mem_resp_valid) begin
                    r_state <= LOOKUP;
                end
                FL_SCAN: begin
                    if (w_line.valid && w_line.dirty) begin
                        r_mem_valid <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= {w_line.cc_tag, r_cnt[IDX_WD-1:0], {OFF_WD{1'b0}}};
                        r_mem_wdata <= w_line.cc_data;
                        r_state     <= FL_REQ;
                    end else if (w_last) begin
                        r_flush_done <= 1'b1;
                        r_idle       <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                FL_REQ: if (mem_req_ready) begin
                    r_mem_valid <= 1'b0;
                    r_state     <= FL_WAIT;
                end
                FL_WAIT: if (mem_resp_valid) begin
                    if (w_last) begin
                        r_flush_done <= 1'b1;
                        r_idle       <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= FL_SCAN;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready     = r_idle && !flush_req;
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;
    assign mem_req_valid = r_mem_valid;
    assign mem_req_we    = r_mem_we;
    assign mem_req_addr  = r_mem_addr;
    assign mem_req_wdata = r_mem_wdata;
    assign flush_done    = r_flush_done;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: a set-level cache model plus a memory responder.
`timescale 1ns/1ps
module tb_dcache_ctrl;
    import mms_pkg::*;

    localparam int TW = C_TAG_WD;
    localparam int IW = C_IDX_WD;
    localparam int OW = C_OFF_WD;
    localparam int DW = C_DW;
    localparam int NS = 1 << IW;
    localparam int AW = TW + IW + OW;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    cache_a_t      req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_we;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_rdata;
    logic          flush_req;
    logic          flush_done;

    dcache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .flush_req(flush_req), .flush_done(flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int last_hold;

    bit            m_valid [NS];
    bit            m_dirty [NS];
    logic [TW-1:0] m_tag   [NS];
    logic [DW-1:0] m_data  [NS];
    logic [DW-1:0] mem [logic [AW-1:0]];

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;
    txn_t exp_q[$];

    function automatic logic [AW-1:0] line_addr(input logic [TW-1:0] t, input logic [IW-1:0] i);
        return {t, i, {OW{1'b0}}};
    endfunction

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        logic [31:0] v;
        if (mem.exists(a)) return mem[a];
        v = (32'(a) * 32'h9E37) ^ 32'h1234;
        return v[DW-1:0];
    endfunction

    // Cache semantics at line granularity: which bus traffic a request implies and the data it returns.
    task automatic model_access(input bit we, input logic [TW-1:0] tag, input logic [IW-1:0] idx,
                                input logic [DW-1:0] wd, output bit hit, output logic [DW-1:0] rd);
        hit = m_valid[idx] && (m_tag[idx] == tag);
        if (!hit) begin
            if (m_valid[idx] && m_dirty[idx])
                exp_q.push_back(txn_t'{we: 1'b1, addr: line_addr(m_tag[idx], idx), wdata: m_data[idx]});
            exp_q.push_back(txn_t'{we: 1'b0, addr: line_addr(tag, idx), wdata: '0});
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tag;
            m_data[idx]  = mem_rd(line_addr(tag, idx));
        end
        if (we) begin
            m_data[idx]  = wd;
            m_dirty[idx] = 1'b1;
        end
        rd = m_data[idx];
    endtask

    task automatic model_flush(output int nwb);
        nwb = 0;
        for (int i = 0; i < NS; i++) begin
            if (m_valid[i] && m_dirty[i]) begin
                exp_q.push_back(txn_t'{we: 1'b1, addr: line_addr(m_tag[i], IW'(i)), wdata: m_data[i]});
                m_dirty[i] = 1'b0;
                nwb++;
            end
        end
    endtask

    // Runs the clock, plays memory, and drops req_valid once accepted; stops on resp_valid or flush_done.
    task automatic service(input bit acc_in, input int stall, input bit want_resp,
                           output bit got, output logic [DW-1:0] rdata, output int lat,
                           output int n_done, output int n_wb);
        int   ms = 0, s = 0, l = 0, since = -1, budget = 3000;
        bit   acc = acc_in;
        bit   fin = 1'b0;
        txn_t obs;
        got = 1'b0; rdata = '0; lat = -1; n_done = 0; n_wb = 0;
        obs = txn_t'{we: 1'b0, addr: '0, wdata: '0};
        while (budget > 0 && !fin) begin
            @(negedge clk);
            budget--;
            flush_req = 1'b0;
            if (acc) begin req_valid = 1'b0; acc = 1'b0; since = 0; end
            if (since >= 0) since++;
            if (req_valid && req_ready) acc = 1'b1;
            if (flush_done) n_done++;
            case (ms)
                0: if (mem_req_valid) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_mem_req: got we=%0b addr=%h, expected no request", mem_req_we, mem_req_addr);
                    end else begin
                        txn_t e = exp_q.pop_front();
                        if (mem_req_we !== e.we || mem_req_addr !== e.addr || (e.we && mem_req_wdata !== e.wdata)) begin
                            n_fail++;
                            $display("FAIL mem_req: got we=%0b addr=%h wdata=%h, expected we=%0b addr=%h wdata=%h",
                                     mem_req_we, mem_req_addr, mem_req_wdata, e.we, e.addr, e.wdata);
                        end
                    end
                    obs = txn_t'{we: mem_req_we, addr: mem_req_addr, wdata: mem_req_wdata};
                    last_hold = 1;
                    if (stall == 0) begin mem_req_ready = 1'b1; ms = 2; end
                    else begin s = stall; ms = 1; end
                end
                1: begin
                    n_checks++;
                    if (mem_req_valid !== 1'b1 || mem_req_we !== obs.we || mem_req_addr !== obs.addr || mem_req_wdata !== obs.wdata) begin
                        n_fail++;
                        $display("FAIL mem_req_stable: got v=%0b addr=%h wdata=%h, expected v=1 addr=%h wdata=%h",
                                 mem_req_valid, mem_req_addr, mem_req_wdata, obs.addr, obs.wdata);
                    end
                    last_hold++;
                    s--;
                    if (s == 0) begin mem_req_ready = 1'b1; ms = 2; end
                end
                2: begin
                    mem_req_ready = 1'b0;
                    n_checks++;
                    if (mem_req_valid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL mem_req_drop: got valid=%0b after handshake, expected 0", mem_req_valid);
                    end
                    if (obs.we) n_wb++;
                    l = $urandom_range(0, 2);
                    ms = 3;
                end
                3: if (l == 0) begin
                    mem_resp_valid = 1'b1;
                    if (obs.we) begin
                        mem[obs.addr]  = obs.wdata;
                        mem_resp_rdata = DW'($urandom);
                    end else begin
                        mem_resp_rdata = mem_rd(obs.addr);
                    end
                    ms = 4;
                end else begin
                    l--;
                end
                default: begin mem_resp_valid = 1'b0; ms = 0; end
            endcase
            if (resp_valid) begin got = 1'b1; rdata = resp_rdata; lat = since; end
            fin = want_resp ? got : (n_done > 0);
        end
        if (!fin) begin
            n_checks++;
            n_fail++;
            $display("FAIL service_timeout: got no %s within budget, expected one", want_resp ? "resp_valid" : "flush_done");
        end
    endtask

    task automatic do_access(input bit we, input logic [TW-1:0] tag, input logic [IW-1:0] idx,
                             input logic [DW-1:0] wd, input int stall,
                             output bit hit, output logic [DW-1:0] rdata);
        logic [DW-1:0] exp_rd;
        bit got;
        int lat, nd, nwb, b;
        b = 0;
        @(negedge clk);
        while (!req_ready && b < 50) begin @(negedge clk); b++; end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready_wait: got %b, expected 1", req_ready);
        end
        model_access(we, tag, idx, wd, hit, exp_rd);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = '{tag: tag, idx: idx, off: OW'($urandom)};
        req_wdata = wd;
        service(1'b1, stall, 1'b1, got, rdata, lat, nd, nwb);
        if (got && !we) begin
            n_checks++;
            if (rdata !== exp_rd) begin
                n_fail++;
                $display("FAIL read_data: got %h, expected %h (tag=%h idx=%0d)", rdata, exp_rd, tag, idx);
            end
        end
        if (got && hit) begin
            n_checks++;
            if (lat != 2) begin
                n_fail++;
                $display("FAIL hit_latency: got %0d, expected 2", lat);
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_mem_req: got %0d outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        logic [2*DW+AW+4:0] outs;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0; flush_req = 1'b0;
        for (int i = 0; i < NS; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; m_data[i] = '0; end
        repeat (3) @(negedge clk);
        outs = {req_ready, resp_valid, mem_req_valid, mem_req_we, flush_done, mem_req_addr, mem_req_wdata, resp_rdata};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected 0", outs);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b, expected 1", req_ready);
        end
    endtask

    task automatic test_read_miss_hit();
        bit hit; logic [DW-1:0] rd;
        mem[line_addr(8'h12, 4'd5)] = 16'hCAFE;
        do_access(1'b0, 8'h12, 4'd5, '0, 0, hit, rd);
        n_checks++;
        if (rd !== 16'hCAFE) begin
            n_fail++;
            $display("FAIL refill_cafe: got %h, expected cafe", rd);
        end
        do_access(1'b0, 8'h12, 4'd5, '0, 0, hit, rd);
        n_checks++;
        if (rd !== 16'hCAFE) begin
            n_fail++;
            $display("FAIL rehit_cafe: got %h, expected cafe", rd);
        end
    endtask

    task automatic test_write_evict();
        bit hit; logic [DW-1:0] rd;
        do_access(1'b1, 8'h12, 4'd5, 16'hBEEF, 0, hit, rd);
        n_checks++;
        if (dut.u_array.r_dirty[5] !== 1'b1) begin
            n_fail++;
            $display("FAIL write_hit_dirty: got %b, expected 1", dut.u_array.r_dirty[5]);
        end
        do_access(1'b0, 8'h34, 4'd5, '0, 1, hit, rd);
        n_checks++;
        if (!mem.exists(line_addr(8'h12, 4'd5)) || mem[line_addr(8'h12, 4'd5)] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL writeback_beef: got %h, expected beef", mem_rd(line_addr(8'h12, 4'd5)));
        end
    endtask

    task automatic test_stall();
        bit hit; logic [DW-1:0] rd;
        do_access(1'b0, 8'h56, 4'd9, '0, 10, hit, rd);
        n_checks++;
        if (last_hold != 11) begin
            n_fail++;
            $display("FAIL stall_hold: got %0d cycles valid, expected 11", last_hold);
        end
    endtask

    task automatic test_flush_vs_req();
        bit hit, got; logic [DW-1:0] rd, exp_rd; int nf, lat, nd, nwb, b;
        do_access(1'b1, 8'h21, 4'd0, 16'h1111, 0, hit, rd);
        do_access(1'b1, 8'h22, IW'(NS-1), 16'h2222, 0, hit, rd);
        b = 0;
        @(negedge clk);
        while (!req_ready && b < 50) begin @(negedge clk); b++; end
        model_flush(nf);
        model_access(1'b0, 8'h12, 4'd3, '0, hit, exp_rd);
        flush_req = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = '{tag: 8'h12, idx: 4'd3, off: '0}; req_wdata = '0;
        service(1'b0, 0, 1'b1, got, rd, lat, nd, nwb);
        n_checks++;
        if (nd != 1) begin
            n_fail++;
            $display("FAIL flush_done_count: got %0d, expected 1", nd);
        end
        n_checks++;
        if (nwb != nf) begin
            n_fail++;
            $display("FAIL flush_wb_count: got %0d, expected %0d", nwb, nf);
        end
        n_checks++;
        if (rd !== exp_rd) begin
            n_fail++;
            $display("FAIL req_after_flush: got %h, expected %h", rd, exp_rd);
        end
        n_checks++;
        if (dut.u_array.r_dirty[0] !== 1'b0 || dut.u_array.r_dirty[NS-1] !== 1'b0 || dut.u_array.r_valid[NS-1] !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_clean: got dirty0=%b dirtyN=%b validN=%b, expected 0 0 1",
                     dut.u_array.r_dirty[0], dut.u_array.r_dirty[NS-1], dut.u_array.r_valid[NS-1]);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL flush_missing_req: got %0d outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_spurious_resp();
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = DW'($urandom);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dut.r_state !== IDLE || resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_state: got state=%0d resp=%b mreq=%b, expected IDLE 0 0", dut.r_state, resp_valid, mem_req_valid);
        end
        for (int i = 0; i < NS; i++) begin
            n_checks++;
            if (dut.u_array.r_valid[i] !== m_valid[i] || dut.u_array.r_dirty[i] !== m_dirty[i] ||
                (m_valid[i] && (dut.u_array.r_tag[i] !== m_tag[i] || dut.u_array.r_data[i] !== m_data[i]))) begin
                n_fail++;
                $display("FAIL spurious_array[%0d]: got v=%b d=%b tag=%h data=%h, expected v=%b d=%b tag=%h data=%h", i,
                         dut.u_array.r_valid[i], dut.u_array.r_dirty[i], dut.u_array.r_tag[i], dut.u_array.r_data[i],
                         m_valid[i], m_dirty[i], m_tag[i], m_data[i]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        bit hit; logic [DW-1:0] rd; int b;
        logic [2*DW+AW+4:0] outs;
        b = 0;
        @(negedge clk);
        while (!req_ready && b < 50) begin @(negedge clk); b++; end
        req_valid = 1'b1; req_we = 1'b0; req_addr = '{tag: 8'h77, idx: 4'd11, off: '0};
        @(negedge clk);
        req_valid = 1'b0;
        b = 0;
        while (!mem_req_valid && b < 50) begin @(negedge clk); b++; end
        n_checks++;
        if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_req_addr !== line_addr(8'h77, 4'd11)) begin
            n_fail++;
            $display("FAIL midflight_rfreq: got v=%b we=%b addr=%h, expected 1 0 %h", mem_req_valid, mem_req_we, mem_req_addr, line_addr(8'h77, 4'd11));
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        outs = {req_ready, resp_valid, mem_req_valid, mem_req_we, flush_done, mem_req_addr, mem_req_wdata, resp_rdata};
        n_checks++;
        if (outs !== '0 || dut.r_state !== IDLE) begin
            n_fail++;
            $display("FAIL midflight_reset: got outs=%h state=%0d, expected 0 IDLE", outs, dut.r_state);
        end
        for (int i = 0; i < NS; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 16'hDEAD;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dut.u_array.r_valid !== '0 || resp_valid !== 1'b0 || dut.r_state !== IDLE) begin
            n_fail++;
            $display("FAIL late_resp: got valid=%h resp=%b state=%0d, expected 0 0 IDLE", dut.u_array.r_valid, resp_valid, dut.r_state);
        end
        do_access(1'b0, 8'h77, 4'd11, '0, 0, hit, rd);
    endtask

    task automatic test_random();
        bit hit, got; logic [DW-1:0] rd; int nf, lat, nd, nwb;
        logic [TW-1:0] pool [4];
        pool[0] = 8'h12; pool[1] = 8'h34; pool[2] = 8'h56; pool[3] = 8'h78;
        for (int k = 0; k < 80; k++) begin
            do_access(1'($urandom), pool[$urandom_range(0, 3)], IW'($urandom_range(0, 3) * 5),
                      DW'($urandom), $urandom_range(0, 3), hit, rd);
        end
        @(negedge clk);
        model_flush(nf);
        flush_req = 1'b1;
        service(1'b0, 1, 1'b0, got, rd, lat, nd, nwb);
        n_checks++;
        if (nwb != nf || nd != 1) begin
            n_fail++;
            $display("FAIL random_flush: got wb=%0d done=%0d, expected wb=%0d done=1", nwb, nd, nf);
        end
        for (int i = 0; i < NS; i++) begin
            n_checks++;
            if (dut.u_array.r_valid[i] !== m_valid[i] || dut.u_array.r_dirty[i] !== m_dirty[i] ||
                (m_valid[i] && (dut.u_array.r_tag[i] !== m_tag[i] || dut.u_array.r_data[i] !== m_data[i]))) begin
                n_fail++;
                $display("FAIL random_array[%0d]: got v=%b d=%b tag=%h data=%h, expected v=%b d=%b tag=%h data=%h", i,
                         dut.u_array.r_valid[i], dut.u_array.r_dirty[i], dut.u_array.r_tag[i], dut.u_array.r_data[i],
                         m_valid[i], m_dirty[i], m_tag[i], m_data[i]);
            end
            if (m_valid[i]) begin
                n_checks++;
                if (mem_rd(line_addr(m_tag[i], IW'(i))) !== m_data[i]) begin
                    n_fail++;
                    $display("FAIL random_mem[%0d]: got %h, expected %h", i, mem_rd(line_addr(m_tag[i], IW'(i))), m_data[i]);
                end
            end
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_read_miss_hit();
        test_write_evict();
        test_stall();
        test_flush_vs_req();
        test_spurious_resp();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1);
    end
endmodule
